// File: rtl/math_issue_queue.sv
// Collapsing issue queue for the math pipe: oldest-first select, tag wakeup, 1-cycle issue.
// Optional second wakeup port enabled by defining MATH_IQ_WAKE1_EN.

module math_iq_wake #(
  parameter int NUM_WAKE = 1
) (
  input  logic [5:0]                rs1,
  input  logic                      rs1_rdy,
  input  logic [5:0]                rs2,
  input  logic                      rs2_rdy,
  input  logic [NUM_WAKE-1:0]       wake_valid,
  input  logic [NUM_WAKE-1:0][5:0]  wake_dest,
  output logic                      rs1_rdy_nxt,
  output logic                      rs2_rdy_nxt
);
  always_comb begin
    rs1_rdy_nxt = rs1_rdy;
    rs2_rdy_nxt = rs2_rdy;
    for (int w = 0; w < NUM_WAKE; w++) begin
      if (wake_valid[w] && wake_dest[w] == rs1) rs1_rdy_nxt = 1'b1;
      if (wake_valid[w] && wake_dest[w] == rs2) rs2_rdy_nxt = 1'b1;
    end
  end
endmodule

module math_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     cpu_clock_i,
  input  logic                     cpu_reset_ni,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [5:0]               enq_rob_i,
  input  logic [5:0]               enq_rs1_i,
  input  logic [5:0]               enq_rs2_i,
  input  logic                     enq_rs1_rdy_i,
  input  logic                     enq_rs2_rdy_i,
  input  logic [5:0]               wake0_dest_i,
  input  logic                     wake0_valid_i,
`ifdef MATH_IQ_WAKE1_EN
  input  logic [5:0]               wake1_dest_i,
  input  logic                     wake1_valid_i,
`endif
  output logic [17:0]              data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
`ifdef MATH_IQ_WAKE1_EN
  localparam int NUM_WAKE = 2;
`else
  localparam int NUM_WAKE = 1;
`endif

  typedef struct packed {
    logic [5:0] rob;
    logic [5:0] rs1;
    logic       rs1_rdy;
    logic [5:0] rs2;
    logic       rs2_rdy;
  } iq_pay_t;

  logic [NUM_WAKE-1:0]      wk_vld;
  logic [NUM_WAKE-1:0][5:0] wk_dest;
`ifdef MATH_IQ_WAKE1_EN
  assign wk_vld  = {wake1_valid_i, wake0_valid_i};
  assign wk_dest = {wake1_dest_i, wake0_dest_i};
`else
  assign wk_vld     = wake0_valid_i;
  assign wk_dest[0] = wake0_dest_i;
`endif

  logic [DEPTH-1:0] q_vld;
  iq_pay_t          q_pay   [DEPTH];
  iq_pay_t          src_pay [DEPTH+1];
  iq_pay_t          woke    [DEPTH+1];
  logic [DEPTH:0]   woke_r1, woke_r2;
  logic [DEPTH:0]   vld_ext;
  logic [DEPTH-1:0] nxt_vld;
  iq_pay_t          nxt_pay [DEPTH];
  logic             iss_hit, enq_fire;
  logic [IW-1:0]    iss_idx;
  logic [CW-1:0]    enq_idx, cnt_nxt;

  // Slot DEPTH of the wake array is the incoming enqueue, so it sees the same-cycle wakeup.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) src_pay[i] = q_pay[i];
    src_pay[DEPTH] = '{rob: enq_rob_i, rs1: enq_rs1_i, rs1_rdy: enq_rs1_rdy_i,
                       rs2: enq_rs2_i, rs2_rdy: enq_rs2_rdy_i};
  end

  for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
    math_iq_wake #(.NUM_WAKE(NUM_WAKE)) u_wake (
      .rs1         (src_pay[g].rs1),
      .rs1_rdy     (src_pay[g].rs1_rdy),
      .rs2         (src_pay[g].rs2),
      .rs2_rdy     (src_pay[g].rs2_rdy),
      .wake_valid  (wk_vld),
      .wake_dest   (wk_dest),
      .rs1_rdy_nxt (woke_r1[g]),
      .rs2_rdy_nxt (woke_r2[g])
    );
  end

  always_comb begin
    for (int i = 0; i <= DEPTH; i++) begin
      woke[i]         = src_pay[i];
      woke[i].rs1_rdy = woke_r1[i];
      woke[i].rs2_rdy = woke_r2[i];
    end
  end

  // Select works on registered rdy bits only, so a just-woken entry waits one cycle.
  always_comb begin
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (q_vld[i] && q_pay[i].rs1_rdy && q_pay[i].rs2_rdy) begin
        iss_hit = 1'b1;
        iss_idx = IW'(i);
      end
    end
  end

  assign enq_ready_o = (count_o < CW'(DEPTH));
  assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
  assign enq_idx     = iss_hit ? count_o - 1'b1 : count_o;
  assign cnt_nxt     = count_o + CW'(enq_fire) - CW'(iss_hit);
  assign vld_ext     = {1'b0, q_vld};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_hit && IW'(i) >= iss_idx) begin
        nxt_vld[i] = vld_ext[i+1];
        nxt_pay[i] = woke[i+1];
      end else begin
        nxt_vld[i] = q_vld[i];
        nxt_pay[i] = woke[i];
      end
      if (enq_fire && CW'(i) == enq_idx) begin
        nxt_vld[i] = 1'b1;
        nxt_pay[i] = woke[DEPTH];
      end
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      q_vld   <= '0;
      count_o <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      q_vld   <= '0;
      count_o <= '0;
      valid_o <= 1'b0;
    end else begin
      q_vld   <= nxt_vld;
      count_o <= cnt_nxt;
      valid_o <= iss_hit;
      if (iss_hit) data_o <= {q_pay[iss_idx].rs2, q_pay[iss_idx].rs1, q_pay[iss_idx].rob};
    end
  end

  // Payload is qualified by q_vld, so it carries no reset.
  always_ff @(posedge cpu_clock_i) begin
    for (int i = 0; i < DEPTH; i++) q_pay[i] <= nxt_pay[i];
  end
endmodule

// File: tb/tb_math_issue_queue.sv
// Directed bench for math_issue_queue (DEPTH=8, single wakeup port).
module tb_math_issue_queue;
  logic        clk, rst_n, flush, enq_v, enq_rdy;
  logic [5:0]  enq_rob, enq_rs1, enq_rs2, wk_dest;
  logic        enq_r1, enq_r2, wk_v;
  logic [17:0] data;
  logic        vld;
  logic [3:0]  cnt;
  int          n_chk, n_fail;

  math_issue_queue #(.DEPTH(8)) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_ni  (rst_n),
    .flush_i       (flush),
    .enq_valid_i   (enq_v),
    .enq_ready_o   (enq_rdy),
    .enq_rob_i     (enq_rob),
    .enq_rs1_i     (enq_rs1),
    .enq_rs2_i     (enq_rs2),
    .enq_rs1_rdy_i (enq_r1),
    .enq_rs2_rdy_i (enq_r2),
    .wake0_dest_i  (wk_dest),
    .wake0_valid_i (wk_v),
    .data_o        (data),
    .valid_o       (vld),
    .count_o       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_enq(input logic v, input logic [5:0] rob, input logic [5:0] rs1,
                         input logic r1, input logic [5:0] rs2, input logic r2);
    enq_v = v; enq_rob = rob; enq_rs1 = rs1; enq_r1 = r1; enq_rs2 = rs2; enq_r2 = r2;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; wk_v = 1'b0; wk_dest = '0;
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    #2;
    chk("rst_count", cnt, 0);
    chk("rst_valid", vld, 0);
    chk("rst_data", data, 0);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_ready", enq_rdy, 1);

    // single ready entry issues the cycle after it lands
    set_enq(1'b1, 6'h04, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t1_cnt1", cnt, 1);
    chk("t1_vld0", vld, 0);
    tick();
    chk("t1_vld", vld, 1);
    chk("t1_data", data, 18'h02044);
    chk("t1_cnt0", cnt, 0);
    tick();
    chk("t1_idle", vld, 0);

    // younger ready entry bypasses older unready one
    set_enq(1'b1, 6'h0A, 6'h10, 1'b0, 6'h11, 1'b1);
    tick();
    set_enq(1'b1, 6'h0B, 6'h12, 1'b1, 6'h13, 1'b1);
    tick();
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t2_cnt2", cnt, 2);
    chk("t2_vld0", vld, 0);
    tick();
    chk("t2_b_vld", vld, 1);
    chk("t2_b_data", data, 18'h1348B);
    chk("t2_cnt1", cnt, 1);
    wk_dest = 6'h10; wk_v = 1'b1;
    tick();
    wk_v = 1'b0;
    chk("t2_wake_noiss", vld, 0);
    tick();
    chk("t2_a_vld", vld, 1);
    chk("t2_a_data", data, 18'h1140A);
    chk("t2_cnt0", cnt, 0);

    // fill to DEPTH with unready entries
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b1, 6'h20 + 6'(i), 6'h30 + 6'(i), 1'b0, 6'h3F, 1'b1);
      tick();
    end
    chk("t3_full_cnt", cnt, 8);
    chk("t3_full_rdy", enq_rdy, 0);
    set_enq(1'b1, 6'h2F, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    chk("t3_ign_cnt", cnt, 8);
    chk("t3_ign_vld", vld, 0);
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    wk_dest = 6'h33; wk_v = 1'b1;
    tick();
    wk_v = 1'b0;
    chk("t3_wake_cnt", cnt, 8);
    chk("t3_wake_vld", vld, 0);
    // freed slot must not be reused in the issue cycle
    set_enq(1'b1, 6'h2E, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t3_iss_vld", vld, 1);
    chk("t3_iss_data", data, 18'h3FCE3);
    chk("t3_iss_cnt", cnt, 7);
    chk("t3_rdy_back", enq_rdy, 1);
    wk_dest = 6'h30; wk_v = 1'b1;
    tick();
    wk_dest = 6'h31;
    tick();
    wk_v = 1'b0;
    chk("t3_oldest_data", data, 18'h3FC20);
    chk("t3_cnt6", cnt, 6);
    tick();
    chk("t3_shift_data", data, 18'h3FC61);
    chk("t3_cnt5", cnt, 5);
    wk_dest = 6'h32; wk_v = 1'b1;
    tick();
    chk("t3_cnt5b", cnt, 5);

    // flush beats enqueue, wakeup and a ready issue candidate
    flush = 1'b1; wk_dest = 6'h34;
    set_enq(1'b1, 6'h2D, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    flush = 1'b0; wk_v = 1'b0;
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t4_flush_cnt", cnt, 0);
    chk("t4_flush_vld", vld, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_post_vld", vld, 0);
      chk("t4_post_cnt", cnt, 0);
    end

    // enqueue catches a same-cycle wakeup
    set_enq(1'b1, 6'h05, 6'h01, 1'b1, 6'h22, 1'b0);
    wk_dest = 6'h22; wk_v = 1'b1;
    tick();
    wk_v = 1'b0;
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t5_cnt1", cnt, 1);
    chk("t5_vld0", vld, 0);
    tick();
    chk("t5_vld", vld, 1);
    chk("t5_data", data, 18'h22045);
    chk("t5_cnt0", cnt, 0);

    // enqueue and issue in the same cycle
    set_enq(1'b1, 6'h07, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    set_enq(1'b1, 6'h08, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t6_x_data", data, 18'h02047);
    chk("t6_cnt1", cnt, 1);
    tick();
    chk("t6_y_data", data, 18'h02048);
    chk("t6_cnt0", cnt, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 6'h31 + 6'(i), 6'h3E, 1'b0, 6'h02, 1'b1);
      tick();
    end
    set_enq(1'b1, 6'h34, 6'h01, 1'b1, 6'h02, 1'b1);
    tick();
    set_enq(1'b0, 6'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    chk("t7_cnt4", cnt, 4);
    tick();
    chk("t7_pre_vld", vld, 1);
    chk("t7_pre_cnt", cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_cnt", cnt, 0);
    chk("t7_async_vld", vld, 0);
    chk("t7_async_data", data, 0);
    tick();
    rst_n = 1'b1;
    chk("t7_rel_rdy", enq_rdy, 1);
    tick();
    chk("t7_after_vld", vld, 0);
    chk("t7_after_cnt", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
